// File: rtl/npu_pkg.sv
// Shared constants for the NPU: widths, FSM state codes and register bit fields.
package npu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned WGT_W   = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned N_OPS   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_MAC   = 4'd1,
        ST_BIAS  = 4'd2,
        ST_ACT   = 4'd3,
        ST_WRITE = 4'd4,
        ST_DONE  = 4'd5
    } npu_state_e;

    // SSFR mode register fields
    localparam int unsigned SSFR_RELU      = 0;
    localparam int unsigned SSFR_SIGNED    = 1;
    localparam int unsigned SSFR_SHIFT_LSB = 2;
    localparam int unsigned SSFR_SHIFT_W   = 3;

    // CON_SIG control register fields
    localparam int unsigned CON_WEN   = 15;
    localparam int unsigned CON_POP   = 14;
    localparam int unsigned CON_CLR   = 13;
    localparam int unsigned CON_WGT_W = N_OPS * WGT_W;

endpackage

// File: rtl/npu_fifo.sv
// Result FIFO: synchronous, first-word-fall-through, head reads 0 when empty.
module npu_fifo
    import npu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state; clear wins over push and pop
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop_ok)  rd_d = rd_q + AW'(1);
            if (push_ok) wr_d = wr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; contents need no reset because the head is gated by empty
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i && !rst_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/npu_top.sv
// NPU top: latches operands on START, runs a 4-term MAC plus bias, then shift,
// ReLU and saturation, and pushes the 8-bit result into the result FIFO.
module npu_top
    import npu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ACC_W      = 16
) (
    input  logic               CLKEXT,
    input  logic               RST_GLO,
    input  logic               START,
    input  logic [15:0]        SSFR,
    input  logic [15:0]        CON_SIG,
    input  logic [DATA_W-1:0]  DA,
    input  logic [DATA_W-1:0]  DB,
    input  logic [DATA_W-1:0]  DC,
    input  logic [DATA_W-1:0]  DD,
    input  logic [DATA_W-1:0]  BIAS_IN,
    output logic [DATA_W-1:0]  D_OUT,
    output logic               FIFO_FULL,
    output logic               FIFO_EMPTY,
    output logic               BUSY,
    output logic               DONE,
    output logic [STATE_W-1:0] STATE_DEBUG
);

    localparam logic signed [ACC_W-1:0] SAT_ZERO = '0;
    localparam logic signed [ACC_W-1:0] SAT_SMAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_SMIN = ACC_W'(-128);
    localparam logic signed [ACC_W-1:0] SAT_UMAX = ACC_W'(255);

    npu_state_e                     state_q, state_d;
    logic [N_OPS-1:0][DATA_W-1:0]   opnd_q, opnd_d;
    logic [N_OPS-1:0][WGT_W-1:0]    wgt_q, wgt_d;
    logic [DATA_W-1:0]              bias_q, bias_d;
    logic                           relu_q, relu_d;
    logic                           sgn_q, sgn_d;
    logic                           wen_q, wen_d;
    logic [SSFR_SHIFT_W-1:0]        shift_q, shift_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic [DATA_W-1:0]              res_q, res_d;

    logic signed [ACC_W-1:0]        x_ext, w_ext, mac_prod, shr, clip;
    logic [DATA_W-1:0]              sat_res;
    logic                           unused_bits;

    assign unused_bits = ^{SSFR[15:SSFR_SHIFT_LSB+SSFR_SHIFT_W], CON_SIG[12]};

    function automatic logic signed [ACC_W-1:0] ext_opnd(input logic [DATA_W-1:0] v,
                                                         input logic sgn);
        return {{(ACC_W-DATA_W){v[DATA_W-1] & sgn}}, v};
    endfunction

    // Current MAC term: selected operand times its weight (fixed +1 when weights are disabled)
    always_comb begin
        x_ext    = ext_opnd(opnd_q[cnt_q], sgn_q);
        w_ext    = wen_q ? {{(ACC_W-WGT_W){wgt_q[cnt_q][WGT_W-1]}}, wgt_q[cnt_q]}
                         : ACC_W'(1);
        mac_prod = x_ext * w_ext;
    end

    // Activation: arithmetic shift, optional ReLU, then clamp to the 8-bit output range
    always_comb begin
        shr  = acc_q >>> shift_q;
        clip = shr;
        if (relu_q && clip < SAT_ZERO) clip = SAT_ZERO;
        if (sgn_q) begin
            if (clip > SAT_SMAX)      clip = SAT_SMAX;
            else if (clip < SAT_SMIN) clip = SAT_SMIN;
        end else begin
            if (clip > SAT_UMAX)      clip = SAT_UMAX;
            else if (clip < SAT_ZERO) clip = SAT_ZERO;
        end
        sat_res = clip[DATA_W-1:0];
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        wgt_d   = wgt_q;
        bias_d  = bias_q;
        relu_d  = relu_q;
        sgn_d   = sgn_q;
        wen_d   = wen_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    opnd_d  = {DD, DC, DB, DA};
                    wgt_d   = CON_SIG[CON_WGT_W-1:0];
                    bias_d  = BIAS_IN;
                    relu_d  = SSFR[SSFR_RELU];
                    sgn_d   = SSFR[SSFR_SIGNED];
                    shift_d = SSFR[SSFR_SHIFT_LSB +: SSFR_SHIFT_W];
                    wen_d   = CON_SIG[CON_WEN];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + mac_prod;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_BIAS;
            end
            ST_BIAS: begin
                acc_d   = acc_q + ext_opnd(bias_q, sgn_q);
                state_d = ST_ACT;
            end
            ST_ACT: begin
                res_d   = sat_res;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            wgt_q   <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            sgn_q   <= 1'b0;
            wen_q   <= 1'b0;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            wgt_q   <= wgt_d;
            bias_q  <= bias_d;
            relu_q  <= relu_d;
            sgn_q   <= sgn_d;
            wen_q   <= wen_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign BUSY        = (state_q == ST_MAC) || (state_q == ST_BIAS) ||
                         (state_q == ST_ACT) || (state_q == ST_WRITE);
    assign DONE        = (state_q == ST_DONE);
    assign STATE_DEBUG = state_q;

    npu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLKEXT),
        .rst_i   (RST_GLO),
        .push_i  (state_q == ST_WRITE),
        .pop_i   (CON_SIG[CON_POP]),
        .clr_i   (CON_SIG[CON_CLR]),
        .din_i   (res_q),
        .dout_o  (D_OUT),
        .full_o  (FIFO_FULL),
        .empty_o (FIFO_EMPTY)
    );

endmodule

// File: tb/tb_npu_top.sv
// Bench for npu_top: directed scenarios plus randomized operations, checked
// against an integer-arithmetic result model and a queue model of the FIFO.
module tb_npu_top;

    localparam int unsigned DEPTH = 8;

    logic        CLKEXT  = 1'b0;
    logic        RST_GLO = 1'b1;
    logic        START   = 1'b0;
    logic [15:0] SSFR    = '0;
    logic [15:0] con_base = '0;
    logic        pop_r   = 1'b0;
    logic        clr_r   = 1'b0;
    logic [15:0] CON_SIG;
    logic [7:0]  DA = '0, DB = '0, DC = '0, DD = '0, BIAS_IN = '0;
    logic [7:0]  D_OUT;
    logic        FIFO_FULL, FIFO_EMPTY, BUSY, DONE;
    logic [3:0]  STATE_DEBUG;

    assign CON_SIG = {con_base[15], pop_r, clr_r, con_base[12:0]};

    npu_top #(
        .FIFO_DEPTH (DEPTH),
        .ACC_W      (16)
    ) dut (
        .CLKEXT      (CLKEXT),
        .RST_GLO     (RST_GLO),
        .START       (START),
        .SSFR        (SSFR),
        .CON_SIG     (CON_SIG),
        .DA          (DA),
        .DB          (DB),
        .DC          (DC),
        .DD          (DD),
        .BIAS_IN     (BIAS_IN),
        .D_OUT       (D_OUT),
        .FIFO_FULL   (FIFO_FULL),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .STATE_DEBUG (STATE_DEBUG)
    );

    always #5 CLKEXT = ~CLKEXT;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_res = '0;
    int         walk_exp [9] = '{1, 1, 1, 1, 2, 3, 4, 5, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Weighted sum, shift, ReLU and clamp computed with plain integers
    function automatic logic [7:0] model(input logic [7:0] a, b, c, d, bi,
                                         input logic [15:0] ssfr, con);
        logic [7:0] x [4];
        int acc, w, v, r;
        x[0] = a; x[1] = b; x[2] = c; x[3] = d;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            v = int'(x[i]);
            if (ssfr[1] && x[i][7]) v -= 256;
            if (con[15]) begin
                w = int'(con[3*i +: 3]);
                if (w >= 4) w -= 8;
            end else begin
                w = 1;
            end
            acc += w * v;
        end
        v = int'(bi);
        if (ssfr[1] && bi[7]) v -= 256;
        acc += v;
        r = acc >>> ssfr[4:2];
        if (ssfr[0] && r < 0) r = 0;
        if (ssfr[1]) begin
            if (r > 127) r = 127;
            if (r < -128) r = -128;
        end else begin
            if (r > 255) r = 255;
            if (r < 0) r = 0;
        end
        return r[7:0];
    endfunction

    // One clock edge: update the FIFO model from the inputs seen at the edge, then compare
    task automatic tick(input bit push_now);
        bit pop_ok, push_ok, rst_s, clr_s;
        rst_s   = RST_GLO;
        clr_s   = clr_r;
        pop_ok  = pop_r && (q.size() > 0);
        push_ok = push_now && ((q.size() < DEPTH) || pop_ok);
        @(posedge CLKEXT);
        #1;
        if (rst_s || clr_s) begin
            q.delete();
        end else begin
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(exp_res);
        end
        check("fifo_head",  D_OUT,      (q.size() > 0) ? q[0] : 8'h00);
        check("fifo_empty", FIFO_EMPTY, q.size() == 0);
        check("fifo_full",  FIFO_FULL,  q.size() == DEPTH);
    endtask

    // pmode: 0 no pops, 1 random pop/clear each cycle, 2 pop only on the push edge
    task automatic run_op(input logic [7:0] a, b, c, d, bi, input logic [15:0] ssfr, con,
                          input int poke, input int pmode);
        DA = a; DB = b; DC = c; DD = d; BIAS_IN = bi;
        SSFR = ssfr; con_base = con;
        exp_res = model(a, b, c, d, bi, ssfr, con);
        START = 1'b1;
        if (pmode == 1) begin
            pop_r = ($urandom_range(0, 3) == 0);
            clr_r = ($urandom_range(0, 15) == 0);
        end
        tick(1'b0);
        START = 1'b0;
        check("accept_state", STATE_DEBUG, 1);
        check("accept_busy",  BUSY, 1);
        DA = 8'($urandom); DB = 8'($urandom); DC = 8'($urandom); DD = 8'($urandom);
        BIAS_IN = 8'($urandom); SSFR = 16'($urandom); con_base = 16'($urandom);
        for (int k = 1; k <= 8; k++) begin
            START = (k == poke);
            if (pmode == 1) begin
                pop_r = ($urandom_range(0, 3) == 0);
                clr_r = ($urandom_range(0, 15) == 0);
            end else if (pmode == 2) begin
                pop_r = (k == 7);
            end
            tick(k == 7);
            check("state_walk", STATE_DEBUG, walk_exp[k]);
            check("done_pulse", DONE, k == 7);
            check("busy",       BUSY, k <= 6);
        end
        START = 1'b0;
        pop_r = 1'b0;
        clr_r = 1'b0;
    endtask

    task automatic reset_dut();
        RST_GLO = 1'b1;
        tick(1'b0);
        tick(1'b0);
        RST_GLO = 1'b0;
        check("rst_busy",  BUSY, 0);
        check("rst_done",  DONE, 0);
        check("rst_state", STATE_DEBUG, 0);
        check("rst_dout",  D_OUT, 8'h00);
        check("rst_empty", FIFO_EMPTY, 1);
        check("rst_full",  FIFO_FULL, 0);
    endtask

    task automatic pop_n(input int n);
        pop_r = 1'b1;
        repeat (n) tick(1'b0);
        pop_r = 1'b0;
    endtask

    initial begin
        // reset state
        reset_dut();

        // saturating plain sum, then a second op leaves the head unchanged
        run_op(8'h12, 8'h34, 8'h56, 8'h78, 8'h10, 16'h0001, 16'h0000, 0, 0);
        check("first_dout",  D_OUT, 8'hFF);
        check("first_empty", FIFO_EMPTY, 0);
        run_op(8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h20, 16'h0001, 16'h0000, 0, 0);
        check("second_head", D_OUT, 8'hFF);
        pop_n(1);
        check("second_entry", D_OUT, 8'hFF);
        check("second_not_empty", FIFO_EMPTY, 0);
        pop_n(1);
        check("two_popped_empty", FIFO_EMPTY, 1);

        // shift by 2
        reset_dut();
        run_op(8'h12, 8'h34, 8'h56, 8'h78, 8'h10, 16'h0009, 16'h0000, 0, 0);
        check("shift2_dout", D_OUT, 8'h49);

        // negative weight, signed, then ReLU after a clear
        reset_dut();
        run_op(8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0002, 16'h8007, 0, 0);
        check("neg_weight_dout", D_OUT, 8'hEE);
        clr_r = 1'b1;
        tick(1'b0);
        clr_r = 1'b0;
        check("clr_empty", FIFO_EMPTY, 1);
        run_op(8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0003, 16'h8007, 0, 0);
        check("relu_dout",  D_OUT, 8'h00);
        check("relu_empty", FIFO_EMPTY, 0);

        // fill to full, drop the ninth, drain in order
        reset_dut();
        for (int i = 1; i <= 9; i++) begin
            run_op(8'(i), 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 0);
            if (i == 8) check("full_after_8", FIFO_FULL, 1);
        end
        check("full_after_9", FIFO_FULL, 1);
        check("head_after_9", D_OUT, 8'h01);
        pop_r = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", D_OUT, 32'(i));
            tick(1'b0);
        end
        pop_r = 1'b0;
        check("drained_empty", FIFO_EMPTY, 1);
        check("drained_dout",  D_OUT, 8'h00);

        // push while full with a simultaneous pop
        for (int i = 1; i <= 8; i++)
            run_op(8'(i), 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 0);
        run_op(8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 2);
        check("full_pushpop_head", D_OUT, 8'h02);
        check("full_pushpop_full", FIFO_FULL, 1);
        pop_n(7);
        check("full_pushpop_tail", D_OUT, 8'h5A);
        pop_n(1);

        // push and pop together on an empty FIFO: only the push happens
        run_op(8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 2);
        check("empty_pushpop_head", D_OUT, 8'h33);
        pop_n(1);

        // START during MAC is ignored
        reset_dut();
        run_op(8'h21, 8'h02, 8'h03, 8'h04, 8'h05, 16'h0000, 16'h0000, 2, 0);
        tick(1'b0);
        check("poke_idle", STATE_DEBUG, 0);
        check("poke_one_entry", D_OUT, 8'h2F);
        pop_n(1);
        check("poke_single_push", FIFO_EMPTY, 1);

        // reset during ACT aborts the operation
        run_op(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 0);
        DA = 8'h11; SSFR = 16'h0000; con_base = 16'h0000;
        START = 1'b1;
        tick(1'b0);
        START = 1'b0;
        repeat (5) tick(1'b0);
        check("abort_in_act", STATE_DEBUG, 3);
        RST_GLO = 1'b1;
        tick(1'b0);
        RST_GLO = 1'b0;
        check("abort_state", STATE_DEBUG, 0);
        check("abort_empty", FIFO_EMPTY, 1);
        check("abort_done",  DONE, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            check("abort_no_done", DONE, 0);
            check("abort_idle", STATE_DEBUG, 0);
        end

        // randomized operations with random pops and clears
        reset_dut();
        for (int n = 0; n < 60; n++) begin
            run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   16'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1);
            if ($urandom_range(0, 4) == 0) begin
                pop_r = 1'b1;
                repeat ($urandom_range(1, 3)) tick(1'b0);
                pop_r = 1'b0;
            end
        end
        pop_n(DEPTH);
        check("final_empty", FIFO_EMPTY, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_top.md
Name: npu_top

Overview:
- Top level of the small neural processing unit.
- On START it latches four 8-bit operands, a bias and the configuration. It then computes one weighted sum (dot product plus bias), applies shift, ReLU and saturation, and pushes the 8-bit result into an output FIFO.
- Status, done pulse and FSM state are exported for the host and debug.

Parameters:
- FIFO_DEPTH, 8, result FIFO entries; power of two, at least 2.
- ACC_W, 16, signed accumulator width.

Ports:
- CLKEXT  in  1  sole clock, rising edge.
- RST_GLO  in  1  reset, synchronous, active-high.
- START  in  1  start request, sampled in IDLE only.
- SSFR  in  16  mode register:
  - [0] RELU_EN
  - [1] SIGNED (operands and bias two's complement)
  - [4:2] SHIFT (arithmetic right shift, 0-7)
  - others reserved
- CON_SIG  in  16  control:
  - [15] WEN
  - [14] FIFO_POP (level)
  - [13] FIFO_CLR
  - [11:0] weights, each 3-bit signed: W_A=[2:0], W_B=[5:3], W_C=[8:6], W_D=[11:9]
- DA, DB, DC, DD  in  8 each  operands.
- BIAS_IN  in  8  bias.
- D_OUT  out  8  FIFO head, first-word-fall-through; 0 when empty.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
- FIFO_EMPTY  out  1  FIFO holds 0 entries.
- BUSY  out  1  high in MAC, BIAS, ACT and WRITE.
- DONE  out  1  one-cycle pulse, high in DONE state.
- STATE_DEBUG  out  4  current state code.

Behaviour:
- Clocking and reset:
  - One clock (CLKEXT); reset RST_GLO is synchronous and active-high.
  - Reset: state IDLE, accumulator and latches 0, FIFO emptied.
  - Reset output values: D_OUT=0, FIFO_EMPTY=1, FIFO_FULL=0, BUSY=0, DONE=0, STATE_DEBUG=0.
  - Reset mid-operation aborts it; nothing is pushed.
- FSM codes: IDLE=0, MAC=1, BIAS=2, ACT=3, WRITE=4, DONE=5.
- FSM transitions:
  - IDLE: on edge with START=1, latch DA..DD, BIAS_IN, SSFR and CON_SIG[15,11:0]; clear acc and cnt; go to MAC.
  - MAC: 4 cycles, cnt 0..3. acc += w[cnt]*x[cnt] with operand order A, B, C, D; then go to BIAS.
  - BIAS: acc += bias, then go to ACT.
  - ACT: r = acc >>> SHIFT. If RELU_EN and r<0, r=0. Saturate to [0,255] when unsigned, [-128,127] when signed. Register the result; go to WRITE.
  - WRITE: push the result; go to DONE.
  - DONE: go to IDLE.
- START outside IDLE is ignored.
- Latency: DONE is high exactly 7 cycles after the accepting edge. The next START is accepted in the cycle after DONE.
- Arithmetic:
  - Unsigned mode: operands and bias zero-extended. Signed mode: sign-extended to ACC_W.
  - Weight is always signed.
  - WEN=0 forces all weights to +1 (plain sum).
  - Worst case magnitude is below 2^15; no overflow handling is needed.
- Inputs are not re-sampled during the operation.
- FIFO:
  - Push only in WRITE.
  - Pop one entry per cycle while FIFO_POP=1 and not empty.
  - Push while full drops the result; contents are unchanged and DONE still pulses.
  - Push and pop in the same cycle: both occur. When full, the push succeeds. When empty, only the push occurs.
  - Pop while empty is ignored.
  - FIFO_CLR empties the FIFO and has priority over push and pop.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a count or an extra pointer bit.

Decomposition:
- Package npu_pkg holds:
  - state encoding constants;
  - SSFR and CON_SIG bit-field positions;
  - widths (data 8, weight 3, state 4).
- Sub-module npu_fifo: synchronous FWFT FIFO with push, pop, clr, full, empty, FIFO_DEPTH parameter, 8-bit data.
- FSM and datapath stay in npu_top.

Test Plan:
- Reset held 2 cycles -> BUSY=0, DONE=0, FIFO_EMPTY=1, FIFO_FULL=0, D_OUT=00, STATE_DEBUG=0.
- SSFR=0001, CON_SIG=0000, DA..DD=12,34,56,78, BIAS=10, START one cycle:
  - STATE_DEBUG walks 1,1,1,1,2,3,4,5,0; DONE is high 7 cycles after acceptance.
  - Sum 292 saturates: D_OUT=FF, FIFO_EMPTY=0.
  - Second op with AB,CD,EF,01, BIAS=20 -> D_OUT still FF (head unchanged), 2 entries.
- SSFR=0009 (shift 2), same operands as the first op, fresh reset -> D_OUT=49.
- Fresh reset, CON_SIG=8007 (W_A=-1, others 0), DA=12, BIAS=00:
  - SSFR=0002 -> D_OUT=EE.
  - Repeat with SSFR=0003 after FIFO_CLR -> D_OUT=00.
- FIFO boundaries:
  - 9 operations with distinct results -> FIFO_FULL after the 8th; the 9th is dropped but DONE still pulses.
  - Hold FIFO_POP 8 cycles -> results appear in order, then FIFO_EMPTY=1 and D_OUT=00.
- START pulsed during MAC -> ignored, single push.
- RST_GLO asserted during ACT -> IDLE next cycle, FIFO empty, no DONE.
